// File: rtl/perf_counter_sampler_if.sv
// Record stream carrying one {index, value} counter sample per beat.
interface perf_counter_sampler_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [3:0]        index;
  logic              last;

  modport master (output valid, data, index, last, input ready);
  modport slave  (input valid, data, index, last, output ready);
endinterface

// File: rtl/perf_counter_sampler.sv
// Sweeps the counter select, captures each counter into a record FIFO and streams the records.
// Sweeps start on trigger or periodic tick; an optional one-cycle counter clear follows a sweep.
module perf_counter_sampler #(
  parameter int NUM_COUNTERS  = 9,
  parameter int SAMPLE_PERIOD = 1024,
  parameter int FIFO_DEPTH    = 16,
  parameter int DATA_W        = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      trigger,
  input  logic                      auto_clear,
  output logic [3:0]                counter_select,
  input  logic [DATA_W-1:0]         counter_data,
  output logic                      counter_reset,
  perf_counter_sampler_if.master    out,
  output logic                      busy,
  output logic                      overflow,
  input  logic                      overflow_clear
);

  localparam int              AW          = $clog2(FIFO_DEPTH);
  localparam int              TW          = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam bit              PERIOD_ON   = (SAMPLE_PERIOD != 0);
  localparam logic [TW-1:0]   PERIOD_LAST = TW'((SAMPLE_PERIOD > 0) ? SAMPLE_PERIOD - 1 : 0);
  localparam logic [3:0]      LAST_IDX    = 4'(NUM_COUNTERS - 1);
  localparam logic [AW:0]     ROOM        = (AW + 1)'(FIFO_DEPTH - NUM_COUNTERS);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_CLEAR} state_t;

  typedef struct packed {
    logic [3:0]        index;
    logic [DATA_W-1:0] data;
  } rec_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          tick, req, start, drop;
  logic          primed, clr_lat, push, pop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  rec_t          mem [FIFO_DEPTH];

  assign tick  = PERIOD_ON && enable && (timer == PERIOD_LAST);
  assign req   = trigger | tick;
  assign start = (state == S_IDLE) && req && (count <= ROOM);
  assign drop  = req && !start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timer <= '0;
    else if (PERIOD_ON && enable)
      timer <= tick ? '0 : timer + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SWEEP;
      S_SWEEP: if (primed && counter_select == LAST_IDX)
                 state_nxt = clr_lat ? S_CLEAR : S_IDLE;
      S_CLEAR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != S_IDLE);
    counter_reset = (state == S_CLEAR);
    push          = (state == S_SWEEP) && primed;
  end

  // First sweep cycle only presents select 0 so the counter block sees a registered select
  // for a full cycle before each capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_select <= '0;
      primed         <= 1'b0;
      clr_lat        <= 1'b0;
    end else if (start) begin
      counter_select <= '0;
      primed         <= 1'b0;
      clr_lat        <= auto_clear;
    end else if (state == S_SWEEP) begin
      if (!primed)
        primed <= 1'b1;
      else if (counter_select == LAST_IDX)
        counter_select <= '0;
      else
        counter_select <= counter_select + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (overflow_clear)
      overflow <= 1'b0;
  end

  // Admission only starts a sweep with room for every record, so push never sees a full FIFO.
  assign pop = out.valid && out.ready;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{index: counter_select, data: counter_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out.valid = (count != '0);
  assign out.data  = mem[rd_ptr].data;
  assign out.index = mem[rd_ptr].index;
  assign out.last  = (mem[rd_ptr].index == LAST_IDX);

endmodule
